rcpu_mem_arbiter: RTL and testbench

RCPU_MEM_ARBITER -- requirements
Module: rcpu_mem_arbiter

---
 rtl/rcpu_mem_arbiter.sv | 117 +++++++++++
 tb/tb_rcpu_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rcpu_mem_arbiter.sv
// Two-requester (CPU / DMA) arbiter onto a single-ported memory; fixed 3-cycle access FSM.
// Define RCPU_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; default build always favours the CPU.
module rcpu_mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          resetq,

    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_rdata,

    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,

    output logic          mem_read_enable,
    output logic [AW-1:0] mem_read_address,
    input  logic [DW-1:0] mem_read_data,
    output logic          mem_write_enable,
    output logic [AW-1:0] mem_write_address,
    output logic [DW-1:0] mem_write_data,

    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    typedef struct packed {
        logic          dma;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t        state, state_nx;
    req_t          req_q, req_nx;
    logic          any_req;
    logic          grant_dma;
    logic          take;
    logic [DW-1:0] cpu_rdata_q, dma_rdata_q;

    assign any_req = cpu_req | dma_req;
    assign take    = (state == IDLE) && any_req;

`ifdef RCPU_ARB_ROUND_ROBIN_EN
    // last_dma remembers who was served last; a tie goes to the other side.
    logic last_dma;

    assign grant_dma = dma_req & (~cpu_req | ~last_dma);

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            last_dma <= 1'b1;
        else if (take)
            last_dma <= grant_dma;
    end
`else
    assign grant_dma = dma_req & ~cpu_req;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ACCESS;
            ACCESS:  state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_nx.dma   = grant_dma;
        req_nx.we    = grant_dma ? dma_we    : cpu_we;
        req_nx.addr  = grant_dma ? dma_addr  : cpu_addr;
        req_nx.wdata = grant_dma ? dma_wdata : cpu_wdata;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state       <= IDLE;
            req_q       <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state <= state_nx;
            // Request fields are frozen from the grant edge until the next IDLE.
            if (take)
                req_q <= req_nx;
            if (state == ACCESS && !req_q.we) begin
                if (req_q.dma) dma_rdata_q <= mem_read_data;
                else           cpu_rdata_q <= mem_read_data;
            end
        end
    end

    // Outputs decode straight from registered state, so reset clears them without waiting for a clock.
    assign busy             = (state != IDLE);
    assign mem_read_enable  = (state == ACCESS) && !req_q.we;
    assign mem_write_enable = (state == ACCESS) &&  req_q.we;
    assign mem_read_address  = mem_read_enable  ? req_q.addr  : '0;
    assign mem_write_address = mem_write_enable ? req_q.addr  : '0;
    assign mem_write_data    = mem_write_enable ? req_q.wdata : '0;

    assign cpu_ack   = (state == ACK) && !req_q.dma;
    assign dma_ack   = (state == ACK) &&  req_q.dma;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_rcpu_mem_arbiter.sv
// Directed bench for rcpu_mem_arbiter: scenario tasks plus an always-on protocol checker.
module tb_rcpu_mem_arbiter;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          resetq;
    logic          cpu_req, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_wdata, dma_wdata;
    logic          cpu_ack, dma_ack;
    logic [DW-1:0] cpu_rdata, dma_rdata;
    logic          mem_read_enable, mem_write_enable;
    logic [AW-1:0] mem_read_address, mem_write_address;
    logic [DW-1:0] mem_read_data, mem_write_data;
    logic          busy;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    rcpu_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .resetq(resetq),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .mem_read_enable(mem_read_enable), .mem_read_address(mem_read_address),
        .mem_read_data(mem_read_data),
        .mem_write_enable(mem_write_enable), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .busy(busy)
    );

    // Memory model: read data available during the enable cycle, writes land on the clock edge.
    assign mem_read_data = mem[mem_read_address];
    always @(posedge clk) if (mem_write_enable) mem[mem_write_address] <= mem_write_data;

    // Every ACCESS cycle has exactly one enable and every ACK cycle one ack, so busy must match.
    always @(negedge clk) begin
        if (resetq === 1'b1) begin
            compared++;
            if ((cpu_ack & dma_ack) !== 1'b0) begin
                mismatched++; $display("FAIL chk_acks: cpu_ack=%b dma_ack=%b required not both", cpu_ack, dma_ack);
            end
            compared++;
            if ((mem_read_enable & mem_write_enable) !== 1'b0) begin
                mismatched++; $display("FAIL chk_enables: re=%b we=%b required not both", mem_read_enable, mem_write_enable);
            end
            compared++;
            if (busy !== (mem_read_enable | mem_write_enable | cpu_ack | dma_ack)) begin
                mismatched++; $display("FAIL chk_busy: busy=%b re=%b we=%b ca=%b da=%b", busy, mem_read_enable, mem_write_enable, cpu_ack, dma_ack);
            end
            compared++;
            if ((!mem_read_enable && mem_read_address !== '0) || (!mem_write_enable && (mem_write_address !== '0 || mem_write_data !== '0))) begin
                mismatched++; $display("FAIL chk_idle_zero: ra=%h wa=%h wd=%h required 0 when disabled", mem_read_address, mem_write_address, mem_write_data);
            end
        end
    end

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    endtask

    task automatic do_reset;
        resetq = 0;
        tick(); tick();
        #3 resetq = 1;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        resetq = 0;
        cpu_req = 1;   // must be ignored while held in reset
        tick(); tick();
        compared++;
        if ({busy, cpu_ack, dma_ack, mem_read_enable, mem_write_enable} !== 5'b0) begin
            mismatched++; $display("FAIL reset_ctrl: got %b required 00000", {busy, cpu_ack, dma_ack, mem_read_enable, mem_write_enable});
        end
        compared++;
        if ({cpu_rdata, dma_rdata, mem_read_address, mem_write_address, mem_write_data} !== '0) begin
            mismatched++; $display("FAIL reset_data: cpu_rdata=%h dma_rdata=%h ra=%h wa=%h wd=%h required 0", cpu_rdata, dma_rdata, mem_read_address, mem_write_address, mem_write_data);
        end
        cpu_req = 0;
        #3 resetq = 1;
        tick();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++; $display("FAIL reset_release_idle: busy=%b required 0", busy);
        end
    endtask

    // Both hold req for 12 cycles: 4 grants expected, one every 3 cycles.
    task automatic test_contention;
        logic [3:0] order;
        int n;
        order = '0; n = 0;
        do_reset();
        cpu_req = 1; cpu_addr = 16'h0012; dma_req = 1; dma_addr = 16'h0012;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (cpu_ack || dma_ack) begin
                if (n < 4) order[n] = dma_ack;
                n++;
            end
        end
        idle_inputs();
        tick(); tick();
        compared++;
        if (n !== 4) begin
            mismatched++; $display("FAIL contention_count: got %0d grants required 4", n);
        end
        compared++;
`ifdef RCPU_ARB_ROUND_ROBIN_EN
        if (order !== 4'b1010) begin   // bit0 first: CPU, DMA, CPU, DMA
            mismatched++; $display("FAIL contention_order: got %b required 1010", order);
        end
`else
        if (order !== 4'b0000) begin
            mismatched++; $display("FAIL contention_order: got %b required 0000", order);
        end
`endif
    endtask

    task automatic test_cpu_read;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        tick();
        compared++;
        if ({mem_read_enable, mem_write_enable, mem_read_address, cpu_ack, busy} !== {1'b1, 1'b0, 16'h0012, 1'b0, 1'b1}) begin
            mismatched++; $display("FAIL cpu_read_access: re=%b we=%b ra=%h ack=%b busy=%b required 1 0 0012 0 1", mem_read_enable, mem_write_enable, mem_read_address, cpu_ack, busy);
        end
        cpu_req = 0;
        tick();
        compared++;
        if ({cpu_ack, dma_ack, mem_read_enable, cpu_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0ABC}) begin
            mismatched++; $display("FAIL cpu_read_ack: ack=%b dack=%b re=%b rdata=%h required 1 0 0 0abc", cpu_ack, dma_ack, mem_read_enable, cpu_rdata);
        end
        tick();
        compared++;
        if ({cpu_ack, busy, cpu_rdata} !== {1'b0, 1'b0, 16'h0ABC}) begin
            mismatched++; $display("FAIL cpu_read_done: ack=%b busy=%b rdata=%h required 0 0 0abc", cpu_ack, busy, cpu_rdata);
        end
    endtask

    task automatic test_dma_write;
        // Seed dma_rdata with a DMA read so "unchanged" is meaningful.
        dma_req = 1; dma_we = 0; dma_addr = 16'h0012;
        tick(); dma_req = 0; tick(); tick();
        dma_req = 1; dma_we = 1; dma_addr = 16'h0100; dma_wdata = 16'h1337;
        tick();
        compared++;
        if ({mem_write_enable, mem_read_enable, mem_write_address, mem_write_data} !== {1'b1, 1'b0, 16'h0100, 16'h1337}) begin
            mismatched++; $display("FAIL dma_write_access: we=%b re=%b wa=%h wd=%h required 1 0 0100 1337", mem_write_enable, mem_read_enable, mem_write_address, mem_write_data);
        end
        idle_inputs();
        tick();
        compared++;
        if ({dma_ack, cpu_ack, mem_write_enable, dma_rdata} !== {1'b1, 1'b0, 1'b0, 16'h0ABC}) begin
            mismatched++; $display("FAIL dma_write_ack: ack=%b cack=%b we=%b rdata=%h required 1 0 0 0abc", dma_ack, cpu_ack, mem_write_enable, dma_rdata);
        end
        compared++;
        if (mem[16'h0100] !== 16'h1337) begin
            mismatched++; $display("FAIL dma_write_mem: mem[0100]=%h required 1337", mem[16'h0100]);
        end
        tick();
    endtask

    task automatic test_addr_hold;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
        tick();
        cpu_addr = 16'h0020; cpu_we = 1; cpu_wdata = 16'hFFFF;
        #2;
        compared++;
        if ({mem_read_enable, mem_write_enable, mem_read_address} !== {1'b1, 1'b0, 16'h0010}) begin
            mismatched++; $display("FAIL addr_hold_access: re=%b we=%b ra=%h required 1 0 0010", mem_read_enable, mem_write_enable, mem_read_address);
        end
        cpu_req = 0;
        tick();
        compared++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h1111}) begin
            mismatched++; $display("FAIL addr_hold_ack: ack=%b rdata=%h required 1 1111", cpu_ack, cpu_rdata);
        end
        idle_inputs();
        tick();
    endtask

    // Requester holds req through ACK; next grant follows after one IDLE cycle.
    task automatic test_back_to_back;
        int acks [$];
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (cpu_ack) acks.push_back(i);
        end
        idle_inputs();
        tick(); tick();
        compared++;
        if (acks.size() !== 2 || acks[0] !== 2 || acks[1] !== 5) begin
            mismatched++; $display("FAIL back_to_back: acks=%p required '{2,5}", acks);
        end
    endtask

    task automatic test_reset_abort;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0012;
        tick();
        cpu_req = 0;
        #1 resetq = 0;
        #1;
        compared++;
        if ({busy, cpu_ack, mem_read_enable, mem_read_address, cpu_rdata} !== '0) begin
            mismatched++; $display("FAIL abort_reset: busy=%b ack=%b re=%b ra=%h rdata=%h required all 0", busy, cpu_ack, mem_read_enable, mem_read_address, cpu_rdata);
        end
        tick();
        compared++;
        if ({busy, cpu_ack} !== 2'b00) begin
            mismatched++; $display("FAIL abort_no_ack: busy=%b ack=%b required 0 0", busy, cpu_ack);
        end
        #3 resetq = 1;
        tick();
        cpu_req = 1; cpu_addr = 16'h0010;
        tick();
        cpu_req = 0;
        tick();
        compared++;
        if ({cpu_ack, cpu_rdata} !== {1'b1, 16'h1111}) begin
            mismatched++; $display("FAIL abort_recover: ack=%b rdata=%h required 1 1111", cpu_ack, cpu_rdata);
        end
        tick();
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        mem[16'h0012] = 16'h0ABC;
        mem[16'h0010] = 16'h1111;
        mem[16'h0020] = 16'h2222;
        test_reset();
        test_contention();
        test_cpu_read();
        test_dma_write();
        test_addr_hold();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
